upconverter_par: RTL and testbench
==================================

UPCONVERTER_PAR -- requirements
Module: upconverter_par

Interface
REQ-001 Parameter W, default 1, sample width in bits; W=1 is ±1 bitstream encoding (1=+1, 0=-1), W>=2 is two's complement.
REQ-002 Parameter LANES, default 4, output samples per clock; legal values 2, 4, 8; any other value SHALL fail elaboration.
REQ-003 aclk  in  1  sole clock; all logic rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 s_valid  in  1  input I/Q sample valid.
REQ-006 s_ready  out  1  block accepts sample this cycle.
REQ-007 s_i  in  W  in-phase sample.
REQ-008 s_q  in  W  quadrature sample.
REQ-009 mode  in  2  0=fs/4 upshift, 1=fs/4 mirror (upshift with Q negated), 2=bypass I, 3=test tone.
REQ-010 phase_clr  in  1  force rotation phase to 0 for the next accepted beat.
REQ-011 m_valid  out  1  output word valid.
REQ-012 m_ready  in  1  downstream serializer accepts word.
REQ-013 m_data  out  LANES*W  output word; lane k at bits [k*W +: W]; lane 0 is transmitted first.
REQ-014 m_phase  out  2  rotation phase used for lane 0 of current m_data.
REQ-015 underflow  out  1  one-cycle pulse per starved cycle.
REQ-016 underflow_cnt  out  16  saturating count of starved cycles.

Function
REQ-017 Beat accepted when s_valid && s_ready; s_ready SHALL equal !m_valid || m_ready (combinational).
REQ-018 Accepted beat SHALL appear on m_data/m_valid exactly 1 cycle later (registered output).
REQ-019 While m_valid && !m_ready, m_data, m_phase and m_valid SHALL hold stable; phase SHALL NOT advance.
REQ-020 m_valid SHALL clear on m_ready when no new beat is accepted in the same cycle.
REQ-021 Lane k uses rotation index r=(p+k) mod 4, where p is the 2-bit phase of the beat.
REQ-022 Mode 0: r=0->I, 1->-Q, 2->-I, 3->Q.
REQ-023 Mode 1: r=0->I, 1->Q, 2->-I, 3->-Q.
REQ-024 Mode 2: every lane = I; phase still advances.
REQ-025 Mode 3: I and Q replaced by +full scale (W=1: 1; W>=2: 2^(W-1)-1), then mode 0 rotation applied.
REQ-026 Negation: W=1 bitwise invert; W>=2 two's complement with saturation, -(-2^(W-1)) = 2^(W-1)-1.
REQ-027 After each accepted beat, p SHALL advance by LANES mod 4 (LANES=2: 0,2,0,...; LANES=4/8: stays 0).
REQ-028 phase_clr high on an accepting cycle: that beat uses p=0 and p then advances from 0; phase_clr on a non-accepting cycle is latched and applied to the next accepted beat.
REQ-029 mode and phase_clr SHALL be sampled only on accepting cycles, with the latched phase_clr exception in REQ-028; a mode change affects only beats accepted after it.
REQ-030 Underflow arms on the first m_valid after reset; once armed, each cycle with m_ready && !m_valid SHALL pulse underflow and increment underflow_cnt, saturating at 16'hFFFF.

Reset
REQ-031 While rst is high: m_valid=0, m_data=0, m_phase=0, p=0, pending phase_clr=0, underflow=0, underflow_cnt=0, underflow disarmed.
REQ-032 While rst is high, s_ready SHALL be 0.
REQ-033 An in-flight word SHALL be discarded on reset, with no partial output afterwards.
REQ-034 The first beat accepted after reset deasserts SHALL use p=0.

Verification
REQ-035 W=1, LANES=4, mode 0, I=1, Q=0, m_ready=1 -> next cycle m_data=4'b0011, m_phase=0.
REQ-036 W=1, LANES=2, mode 0, two beats with I=1, Q=1 -> m_data=2'b01 (m_phase=0), then 2'b10 (m_phase=2); phase_clr on beat 2 -> 2'b01 with m_phase=0.
REQ-037 W=4, LANES=4, mode 0, I=4'h8, Q=0 -> m_data=16'h0708, showing saturated negate of -8.
REQ-038 Beat held with m_ready=0 for 3 cycles -> m_data constant, s_ready=0, m_phase unchanged; the next beat uses the following phase.
REQ-039 After one beat, m_ready=1 and s_valid=0 for 5 cycles -> 5 underflow pulses and underflow_cnt=5; forcing the count past 16'hFFFF -> holds 16'hFFFF.
REQ-040 rst asserted for 1 cycle while m_valid=1 and LANES=2 with p=2 -> m_valid=0, underflow_cnt=0, and the next beat gets m_phase=0.

Source files
------------

// File: rtl/upconverter_par_if.sv
// Sample-in / word-out handshake bundle for upconverter_par.
interface upconverter_par_if #(
  parameter int W     = 1,
  parameter int LANES = 4
);
  logic                 s_valid;
  logic                 s_ready;
  logic [W-1:0]         s_i;
  logic [W-1:0]         s_q;
  logic                 m_valid;
  logic                 m_ready;
  logic [LANES*W-1:0]   m_data;
  logic [1:0]           m_phase;

  modport master (
    output s_valid, s_i, s_q, m_ready,
    input  s_ready, m_valid, m_data, m_phase
  );

  modport slave (
    input  s_valid, s_i, s_q, m_ready,
    output s_ready, m_valid, m_data, m_phase
  );
endinterface

// File: rtl/upconverter_par.sv
// Parallel fs/4 digital upconverter: one I/Q beat in, LANES rotated samples out.
module upconverter_par #(
  parameter int W     = 1,
  parameter int LANES = 4
) (
  input  logic                aclk,
  input  logic                rst,
  upconverter_par_if.slave    bus,
  input  logic [1:0]          mode,
  input  logic                phase_clr,
  output logic                underflow,
  output logic [15:0]         underflow_cnt
);

  if (!(LANES == 2 || LANES == 4 || LANES == 8)) begin : g_lanes_check
    $error("upconverter_par: LANES must be 2, 4 or 8");
  end

  localparam logic [W-1:0] SIGN = W'(1) << (W - 1);
  localparam logic [W-1:0] FULL = (W == 1) ? W'(1) : ~SIGN;
  localparam logic [1:0]   STEP = 2'(LANES % 4);

  logic                 valid_q;
  logic [LANES*W-1:0]   data_q;
  logic [1:0]           phase_q;
  logic [1:0]           p;
  logic                 clr_pend;
  logic                 armed;
  logic [15:0]          cnt_q;

  logic                 ready;
  logic                 accept;
  logic                 starved;
  logic [1:0]           p_use;
  logic [LANES*W-1:0]   word;
  logic [W-1:0]         iv;
  logic [W-1:0]         qv;
  logic [W-1:0]         lane;
  logic [1:0]           r;

  // W=1 is a +/-1 bitstream, so negation is inversion; wider words saturate the most negative code.
  function automatic logic [W-1:0] neg(input logic [W-1:0] x);
    if (W == 1)
      return ~x;
    else if (x == SIGN)
      return ~SIGN;
    else
      return ~x + W'(1);
  endfunction

  // Handshake, effective phase and starvation detect.
  always_comb begin
    ready   = !rst && (!valid_q || bus.m_ready);
    accept  = bus.s_valid && ready;
    p_use   = (phase_clr || clr_pend) ? 2'b00 : p;
    starved = !rst && armed && bus.m_ready && !valid_q;
  end

  // Build the rotated output word for the beat on the input this cycle.
  always_comb begin
    word = '0;
    iv   = (mode == 2'd3) ? FULL : bus.s_i;
    qv   = (mode == 2'd3) ? FULL : bus.s_q;
    lane = '0;
    r    = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      r = p_use + 2'(k);
      case (mode)
        2'd2: lane = iv;
        2'd1: begin
          case (r)
            2'd0:    lane = iv;
            2'd1:    lane = qv;
            2'd2:    lane = neg(iv);
            default: lane = neg(qv);
          endcase
        end
        default: begin
          case (r)
            2'd0:    lane = iv;
            2'd1:    lane = neg(qv);
            2'd2:    lane = neg(iv);
            default: lane = qv;
          endcase
        end
      endcase
      word[k*W +: W] = lane;
    end
  end

  // Output register, rotation phase and latched phase clear.
  always_ff @(posedge aclk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      phase_q  <= '0;
      p        <= '0;
      clr_pend <= 1'b0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      data_q   <= word;
      phase_q  <= p_use;
      p        <= p_use + STEP;
      clr_pend <= 1'b0;
    end else begin
      if (bus.m_ready)
        valid_q <= 1'b0;
      if (phase_clr)
        clr_pend <= 1'b1;
    end
  end

  // Underflow arming and saturating starved-cycle counter.
  always_ff @(posedge aclk) begin
    if (rst) begin
      armed <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (valid_q)
        armed <= 1'b1;
      if (starved && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.s_ready   = ready;
  assign bus.m_valid   = valid_q;
  assign bus.m_data    = data_q;
  assign bus.m_phase   = phase_q;
  assign underflow     = starved;
  assign underflow_cnt = cnt_q;

endmodule

// File: tb/tb_upconverter_par.sv
// Directed/random bench for upconverter_par on three parameter sets with a scoreboard.
module tb_upconverter_par;

  logic aclk;
  logic rst;

  logic [1:0]  mode_a, mode_b, mode_c;
  logic        pclr_a, pclr_b, pclr_c;
  logic        uf_a, uf_b, uf_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  upconverter_par_if #(.W(1), .LANES(4)) ifa ();
  upconverter_par_if #(.W(1), .LANES(2)) ifb ();
  upconverter_par_if #(.W(4), .LANES(4)) ifc ();

  upconverter_par #(.W(1), .LANES(4)) dut_a (
    .aclk(aclk), .rst(rst), .bus(ifa), .mode(mode_a), .phase_clr(pclr_a),
    .underflow(uf_a), .underflow_cnt(cnt_a)
  );
  upconverter_par #(.W(1), .LANES(2)) dut_b (
    .aclk(aclk), .rst(rst), .bus(ifb), .mode(mode_b), .phase_clr(pclr_b),
    .underflow(uf_b), .underflow_cnt(cnt_b)
  );
  upconverter_par #(.W(4), .LANES(4)) dut_c (
    .aclk(aclk), .rst(rst), .bus(ifc), .mode(mode_c), .phase_clr(pclr_c),
    .underflow(uf_c), .underflow_cnt(cnt_c)
  );

  typedef struct {
    logic [15:0] data;
    logic [1:0]  ph;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  int checks = 0;
  int errors = 0;
  int uf_seen = 0;
  int w_of[3]     = '{1, 1, 4};
  int lanes_of[3] = '{4, 2, 4};
  logic [1:0] p_m[3];
  logic       pend_m[3];

  logic        o_ready, o_valid, o_uf, pre_ready;
  logic [15:0] o_data, o_cnt;
  logic [1:0]  o_phase;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Independent reference: signed integer arithmetic with clamping.
  function automatic logic [15:0] model(int w, int lanes, logic [1:0] md,
                                        logic [3:0] i, logic [3:0] q, logic [1:0] p);
    int iv, qv, v, mx, r;
    logic [15:0] res;
    mx = (w == 1) ? 1 : (1 << (w - 1)) - 1;
    if (w == 1) begin
      iv = i[0] ? 1 : -1;
      qv = q[0] ? 1 : -1;
    end else begin
      iv = int'(i);
      qv = int'(q);
      if (iv >= (1 << (w - 1))) iv -= (1 << w);
      if (qv >= (1 << (w - 1))) qv -= (1 << w);
    end
    if (md == 2'd3) begin
      iv = mx;
      qv = mx;
    end
    res = '0;
    for (int k = 0; k < lanes; k++) begin
      r = (int'(p) + k) % 4;
      if (md == 2'd2)      v = iv;
      else if (md == 2'd1) v = (r == 0) ? iv : (r == 1) ? qv : (r == 2) ? -iv : -qv;
      else                 v = (r == 0) ? iv : (r == 1) ? -qv : (r == 2) ? -iv : qv;
      if (v > mx) v = mx;
      if (w == 1) res[k] = (v > 0);
      else for (int b = 0; b < w; b++) res[k*w + b] = v[b];
    end
    return res;
  endfunction

  task automatic idle_all();
    ifa.s_valid = 0; ifa.s_i = '0; ifa.s_q = '0; ifa.m_ready = 0; mode_a = 0; pclr_a = 0;
    ifb.s_valid = 0; ifb.s_i = '0; ifb.s_q = '0; ifb.m_ready = 0; mode_b = 0; pclr_b = 0;
    ifc.s_valid = 0; ifc.s_i = '0; ifc.s_q = '0; ifc.m_ready = 0; mode_c = 0; pclr_c = 0;
  endtask

  task automatic set_in(input int id, input logic v, input logic [3:0] i, input logic [3:0] q,
                        input logic [1:0] md, input logic pc, input logic rdy);
    case (id)
      0: begin ifa.s_valid = v; ifa.s_i = i[0]; ifa.s_q = q[0]; mode_a = md; pclr_a = pc; ifa.m_ready = rdy; end
      1: begin ifb.s_valid = v; ifb.s_i = i[0]; ifb.s_q = q[0]; mode_b = md; pclr_b = pc; ifb.m_ready = rdy; end
      default: begin ifc.s_valid = v; ifc.s_i = i; ifc.s_q = q; mode_c = md; pclr_c = pc; ifc.m_ready = rdy; end
    endcase
  endtask

  task automatic read_out(input int id);
    case (id)
      0: begin o_ready = ifa.s_ready; o_valid = ifa.m_valid; o_data = 16'(ifa.m_data);
               o_phase = ifa.m_phase; o_uf = uf_a; o_cnt = cnt_a; end
      1: begin o_ready = ifb.s_ready; o_valid = ifb.m_valid; o_data = 16'(ifb.m_data);
               o_phase = ifb.m_phase; o_uf = uf_b; o_cnt = cnt_b; end
      default: begin o_ready = ifc.s_ready; o_valid = ifc.m_valid; o_data = 16'(ifc.m_data);
               o_phase = ifc.m_phase; o_uf = uf_c; o_cnt = cnt_c; end
    endcase
  endtask

  // One clock cycle on instance id; pushes expectations on accept and checks them one cycle later.
  task automatic cyc(input int id, input logic v, input logic [3:0] i, input logic [3:0] q,
                     input logic [1:0] md, input logic pc, input logic rdy);
    logic acc;
    logic [1:0] pu;
    exp_t e;
    @(negedge aclk);
    idle_all();
    set_in(id, v, i, q, md, pc, rdy);
    #1;
    read_out(id);
    pre_ready = o_ready;
    uf_seen += int'(o_uf);
    acc = v && o_ready;
    if (acc) begin
      pu = (pc || pend_m[id]) ? 2'd0 : p_m[id];
      e.data = model(w_of[id], lanes_of[id], md, i, q, pu);
      e.ph = pu;
      sb.push_back(e);
      p_m[id] = 2'((int'(pu) + lanes_of[id]) % 4);
      pend_m[id] = 1'b0;
    end else if (pc) begin
      pend_m[id] = 1'b1;
    end
    @(posedge aclk);
    #1;
    read_out(id);
    if (acc) begin
      last_exp = sb.pop_front();
      chk("beat_valid", 32'(o_valid), 32'd1);
      chk("beat_data", 32'(o_data), 32'(last_exp.data));
      chk("beat_phase", 32'(o_phase), 32'(last_exp.ph));
    end
  endtask

  task automatic rst_dut(input int id);
    @(negedge aclk);
    idle_all();
    set_in(id, 0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    #1;
    read_out(id);
    chk("rst_s_ready", 32'(o_ready), 32'd0);
    chk("rst_underflow", 32'(o_uf), 32'd0);
    @(posedge aclk);
    #1;
    read_out(id);
    chk("rst_m_valid", 32'(o_valid), 32'd0);
    chk("rst_m_data", 32'(o_data), 32'd0);
    chk("rst_m_phase", 32'(o_phase), 32'd0);
    chk("rst_uf_cnt", 32'(o_cnt), 32'd0);
    @(negedge aclk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      p_m[k] = 2'd0;
      pend_m[k] = 1'b0;
    end
    sb.delete();
    uf_seen = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();

    // W=1, LANES=4
    rst_dut(0);
    cyc(0, 1, 4'd1, 4'd0, 2'd0, 0, 1);
    chk("fs4_w1_l4_data", 32'(o_data), 32'h3);
    chk("fs4_w1_l4_phase", 32'(o_phase), 32'd0);
    for (int n = 0; n < 8; n++)
      cyc(0, 1, 4'($urandom), 4'($urandom), 2'($urandom_range(0, 3)), 0, 1);

    // Underflow pulses and saturation
    rst_dut(0);
    cyc(0, 1, 4'd1, 4'd1, 2'd0, 0, 1);
    uf_seen = 0;
    repeat (6) cyc(0, 0, 4'd0, 4'd0, 2'd0, 0, 1);
    chk("uf_pulses", 32'(uf_seen), 32'd5);
    chk("uf_cnt5", 32'(o_cnt), 32'd5);
    repeat (65529) @(posedge aclk);
    #1; read_out(0);
    chk("uf_cnt_fffe", 32'(o_cnt), 32'hFFFE);
    @(posedge aclk);
    #1; read_out(0);
    chk("uf_cnt_ffff", 32'(o_cnt), 32'hFFFF);
    repeat (4) @(posedge aclk);
    #1; read_out(0);
    chk("uf_cnt_sat", 32'(o_cnt), 32'hFFFF);

    // W=1, LANES=2: phase sequence and phase_clr
    rst_dut(1);
    cyc(1, 1, 4'd1, 4'd1, 2'd0, 0, 1);
    chk("l2_beat1_data", 32'(o_data), 32'h1);
    chk("l2_beat1_phase", 32'(o_phase), 32'd0);
    cyc(1, 1, 4'd1, 4'd1, 2'd0, 0, 1);
    chk("l2_beat2_data", 32'(o_data), 32'h2);
    chk("l2_beat2_phase", 32'(o_phase), 32'd2);
    cyc(1, 1, 4'd1, 4'd1, 2'd0, 1, 1);
    chk("l2_clr_data", 32'(o_data), 32'h1);
    chk("l2_clr_phase", 32'(o_phase), 32'd0);
    cyc(1, 0, 4'd0, 4'd0, 2'd3, 1, 1);
    cyc(1, 1, 4'd1, 4'd1, 2'd0, 0, 1);
    chk("l2_latched_clr_phase", 32'(o_phase), 32'd0);

    // Backpressure hold
    cyc(1, 0, 4'd0, 4'd0, 2'd0, 0, 1);
    cyc(1, 1, 4'd1, 4'd0, 2'd1, 0, 0);
    chk("hold_first_phase", 32'(o_phase), 32'd2);
    for (int n = 0; n < 3; n++) begin
      cyc(1, 1, 4'd0, 4'd1, 2'd0, 0, 0);
      chk("hold_s_ready", 32'(pre_ready), 32'd0);
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_data", 32'(o_data), 32'(last_exp.data));
      chk("hold_phase", 32'(o_phase), 32'(last_exp.ph));
    end
    cyc(1, 1, 4'd1, 4'd1, 2'd0, 0, 1);
    chk("after_hold_phase", 32'(o_phase), 32'd0);
    for (int n = 0; n < 16; n++)
      cyc(1, 1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));

    // Reset with a word in flight at p=2
    repeat (3) cyc(1, 0, 4'd0, 4'd0, 2'd0, 0, 1);
    cyc(1, 1, 4'd1, 4'd1, 2'd0, 1, 0);
    cyc(1, 0, 4'd0, 4'd0, 2'd0, 0, 0);
    chk("pre_rst_valid", 32'(o_valid), 32'd1);
    chk("pre_rst_cnt_nonzero", 32'(o_cnt != 16'd0), 32'd1);
    rst_dut(1);
    cyc(1, 1, 4'd1, 4'd1, 2'd0, 0, 1);
    chk("post_rst_phase", 32'(o_phase), 32'd0);
    chk("post_rst_data", 32'(o_data), 32'h1);

    // W=4, LANES=4: saturated negate and all modes
    rst_dut(2);
    cyc(2, 1, 4'h8, 4'h0, 2'd0, 0, 1);
    chk("w4_sat_neg", 32'(o_data), 32'h0708);
    for (int md = 0; md < 4; md++) begin
      cyc(2, 1, 4'h8, 4'h8, 2'(md), 0, 1);
      cyc(2, 1, 4'h7, 4'h1, 2'(md), 0, 1);
      cyc(2, 1, 4'($urandom), 4'($urandom), 2'(md), 0, 1);
    end
    for (int n = 0; n < 16; n++)
      cyc(2, 1'($urandom), 4'($urandom), 4'($urandom), 2'($urandom_range(0, 3)),
          1'($urandom), 1'($urandom_range(0, 3) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
